// File: rtl/ppm_slot_decoder.sv
// Pulse-position-modulation slot decoder: synchronizes and width-qualifies the raw line,
// then reports the slot index of the single pulse found in each fixed-length frame.
module ppm_slot_decoder #(
  parameter int unsigned SLOT_CYCLES = 25,
  parameter int unsigned NUM_SLOTS   = 5,
  parameter int unsigned MIN_PULSE   = 2
) (
  input  logic       clk1m,
  input  logic       reset_n,
  input  logic       ppm_in,
  input  logic       auto_reset_n,
  output logic       ppm_pulse,
  output logic [2:0] sym_data,
  output logic       sym_valid,
  output logic       sym_err,
  output logic       frame_active
);

  localparam logic [7:0] SubLast  = 8'(SLOT_CYCLES - 1);
  localparam logic [2:0] SlotLast = 3'(NUM_SLOTS - 1);
  localparam logic [3:0] HiFull   = 4'(MIN_PULSE);
  localparam logic [3:0] HiArm    = 4'(MIN_PULSE - 1);

  typedef enum logic [0:0] {
    StIdle,
    StMeasure
  } state_e;

  // Input conditioning
  logic       ppm_meta_q;
  logic       ppm_s_q;
  logic [3:0] hi_cnt_q, hi_cnt_d;
  logic       ppm_pulse_q, ppm_pulse_d;

  // Frame tracking
  state_e     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] sub_q, sub_d;
  logic [1:0] pcnt_q, pcnt_d;
  logic [2:0] cap_slot_q, cap_slot_d;
  logic       err_seen_q, err_seen_d;

  // Registered outputs
  logic       sym_valid_q, sym_valid_d;
  logic       sym_err_q, sym_err_d;
  logic [2:0] sym_data_q, sym_data_d;
  logic       frame_active_q, frame_active_d;

  logic       frame_end;
  logic [1:0] pcnt_inc;
  logic       frame_bad;

  always_ff @(posedge clk1m or negedge reset_n) begin
    if (!reset_n) begin
      ppm_meta_q <= 1'b0;
      ppm_s_q    <= 1'b0;
    end else begin
      ppm_meta_q <= ppm_in;
      ppm_s_q    <= ppm_meta_q;
    end
  end

  // The strobe fires only on the MIN_PULSE-1 -> MIN_PULSE step, so a long high run
  // produces exactly one pulse and a new one needs ppm_s to drop first.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (!ppm_s_q) begin
      hi_cnt_d = '0;
    end else if (hi_cnt_q != HiFull) begin
      hi_cnt_d = hi_cnt_q + 4'd1;
    end
    ppm_pulse_d = ppm_s_q && (hi_cnt_q == HiArm);
  end

  always_ff @(posedge clk1m or negedge reset_n) begin
    if (!reset_n) begin
      hi_cnt_q    <= '0;
      ppm_pulse_q <= 1'b0;
    end else begin
      hi_cnt_q    <= hi_cnt_d;
      ppm_pulse_q <= ppm_pulse_d;
    end
  end

  // Pulse count for the current frame including a pulse accepted this very cycle.
  always_comb begin
    frame_end = (state_q == StMeasure) && (slot_q == SlotLast) && (sub_q == SubLast);
    pcnt_inc  = pcnt_q;
    if (ppm_pulse_q && (pcnt_q != 2'd2)) begin
      pcnt_inc = pcnt_q + 2'd1;
    end
    frame_bad = (pcnt_inc != 2'd1);
  end

  // FSM: state register
  always_ff @(posedge clk1m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (auto_reset_n && ppm_pulse_q) begin
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (!auto_reset_n) begin
          state_d = StIdle;
        end else if (frame_end && frame_bad && err_seen_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sym_valid_d    = 1'b0;
    sym_err_d      = 1'b0;
    sym_data_d     = sym_data_q;
    frame_active_d = (state_d == StMeasure);
    if (auto_reset_n && frame_end) begin
      if (frame_bad) begin
        sym_err_d = 1'b1;
      end else begin
        sym_valid_d = 1'b1;
        // A pulse on the last cycle is the only one, so the capture register is stale.
        sym_data_d  = ppm_pulse_q ? slot_q : cap_slot_q;
      end
    end
  end

  always_ff @(posedge clk1m or negedge reset_n) begin
    if (!reset_n) begin
      sym_valid_q    <= 1'b0;
      sym_err_q      <= 1'b0;
      sym_data_q     <= '0;
      frame_active_q <= 1'b0;
    end else begin
      sym_valid_q    <= sym_valid_d;
      sym_err_q      <= sym_err_d;
      sym_data_q     <= sym_data_d;
      frame_active_q <= frame_active_d;
    end
  end

  // Frame position is kept as slot + intra-slot counters so no divider is needed.
  always_comb begin
    slot_d     = slot_q;
    sub_d      = sub_q;
    pcnt_d     = pcnt_q;
    cap_slot_d = cap_slot_q;
    err_seen_d = err_seen_q;
    if (!auto_reset_n || (state_q == StIdle)) begin
      slot_d     = '0;
      sub_d      = '0;
      pcnt_d     = '0;
      err_seen_d = 1'b0;
    end else begin
      if (sub_q == SubLast) begin
        sub_d  = '0;
        slot_d = (slot_q == SlotLast) ? 3'd0 : slot_q + 3'd1;
      end else begin
        sub_d = sub_q + 8'd1;
      end
      if (ppm_pulse_q) begin
        cap_slot_d = slot_q;
      end
      if (frame_end) begin
        pcnt_d     = '0;
        err_seen_d = frame_bad && !err_seen_q;
      end else begin
        pcnt_d = pcnt_inc;
      end
    end
  end

  always_ff @(posedge clk1m or negedge reset_n) begin
    if (!reset_n) begin
      slot_q     <= '0;
      sub_q      <= '0;
      pcnt_q     <= '0;
      cap_slot_q <= '0;
      err_seen_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      sub_q      <= sub_d;
      pcnt_q     <= pcnt_d;
      cap_slot_q <= cap_slot_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign ppm_pulse    = ppm_pulse_q;
  assign sym_valid    = sym_valid_q;
  assign sym_err      = sym_err_q;
  assign sym_data     = sym_data_q;
  assign frame_active = frame_active_q;

endmodule

// File: tb/tb_ppm_slot_decoder.sv
// Bench for ppm_slot_decoder: frame-level reference model compared every cycle,
// plus hand-computed expectations at chosen edges.
module tb_ppm_slot_decoder;

  localparam int SlotCycles = 25;
  localparam int NumSlots   = 5;
  localparam int MinPulse   = 2;
  localparam int FrameLen   = SlotCycles * NumSlots;
  localparam int HistDepth  = MinPulse + 3;

  logic       clk1m = 1'b0;
  logic       reset_n;
  logic       ppm_in;
  logic       auto_reset_n;
  logic       ppm_pulse;
  logic [2:0] sym_data;
  logic       sym_valid;
  logic       sym_err;
  logic       frame_active;

  ppm_slot_decoder #(
    .SLOT_CYCLES(SlotCycles),
    .NUM_SLOTS  (NumSlots),
    .MIN_PULSE  (MinPulse)
  ) dut (
    .clk1m       (clk1m),
    .reset_n     (reset_n),
    .ppm_in      (ppm_in),
    .auto_reset_n(auto_reset_n),
    .ppm_pulse   (ppm_pulse),
    .sym_data    (sym_data),
    .sym_valid   (sym_valid),
    .sym_err     (sym_err),
    .frame_active(frame_active)
  );

  always #5 clk1m = ~clk1m;

  int checks   = 0;
  int passes   = 0;
  int edge_cnt = 0;

  typedef struct {
    int    edge_no;
    int    sig;
    int    val;
    string name;
  } pin_t;
  pin_t pins[$];
  int   pins_hit = 0;

  // Reference model state
  bit hist [HistDepth];
  bit exp_pulse, exp_valid, exp_err, measuring;
  int exp_data, frame_pos, errs;
  int slots[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s at edge %0d: got %0d, required %0d", name, edge_cnt, act, req);
  endtask

  function automatic int sig_value(input int sig);
    case (sig)
      0:       return int'(ppm_pulse);
      1:       return int'(sym_valid);
      2:       return int'(sym_err);
      3:       return int'(sym_data);
      4:       return int'(frame_active);
      default: return -1;
    endcase
  endfunction

  task automatic pin(input int edge_no, input int sig, input int val, input string name);
    pin_t p;
    p.edge_no = edge_no;
    p.sig     = sig;
    p.val     = val;
    p.name    = name;
    pins.push_back(p);
  endtask

  task automatic model_reset();
    for (int i = 0; i < HistDepth; i++) hist[i] = 1'b0;
    exp_pulse = 0; exp_valid = 0; exp_err = 0; measuring = 0;
    exp_data  = 0; frame_pos = 0; errs = 0;
    slots.delete();
  endtask

  // One clock edge of the model; the FSM reacts to the pulse visible before the edge.
  task automatic model_step();
    int cyc;
    bit w;
    exp_valid = 0;
    exp_err   = 0;
    if (!auto_reset_n) begin
      measuring = 0;
      errs      = 0;
      slots.delete();
    end else if (!measuring) begin
      if (exp_pulse) begin
        measuring = 1;
        frame_pos = 0;
        slots.delete();
      end
    end else begin
      cyc = frame_pos % FrameLen;
      if (exp_pulse) slots.push_back(cyc / SlotCycles);
      if (cyc == FrameLen - 1) begin
        if (slots.size() == 1) begin
          exp_valid = 1;
          exp_data  = slots[0];
          errs      = 0;
        end else begin
          exp_err = 1;
          errs++;
          if (errs == 2) begin
            measuring = 0;
            errs      = 0;
          end
        end
        slots.delete();
      end
      frame_pos++;
    end
    // Pulse appears once the raw high run, seen two edges late, is exactly MinPulse long.
    for (int i = HistDepth - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ppm_in;
    w = 1;
    for (int j = 2; j < MinPulse + 2; j++) if (!hist[j]) w = 0;
    if (hist[MinPulse+2]) w = 0;
    exp_pulse = w;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk1m);
      edge_cnt++;
      #1;
      if (!reset_n) model_reset();
      else model_step();
      check("ppm_pulse", int'(ppm_pulse), int'(exp_pulse));
      check("sym_valid", int'(sym_valid), int'(exp_valid));
      check("sym_err", int'(sym_err), int'(exp_err));
      check("sym_data", int'(sym_data), exp_data);
      check("frame_active", int'(frame_active), int'(measuring));
      foreach (pins[i]) begin
        if (pins[i].edge_no == edge_cnt) begin
          pins_hit++;
          check(pins[i].name, sig_value(pins[i].sig), pins[i].val);
        end
      end
    end
  end

  task automatic wait_neg(input int edge_no);
    while (edge_cnt < edge_no) @(negedge clk1m);
  endtask

  // First sampling edge of the high run is first_edge; it stays high for len edges.
  task automatic drive_high(input int first_edge, input int len);
    wait_neg(first_edge - 1);
    ppm_in = 1'b1;
    repeat (len) @(negedge clk1m);
    ppm_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  int a, b, e, e2, e3, g, e4, e5;

  initial begin
    reset_n      = 1'b0;
    ppm_in       = 1'b0;
    auto_reset_n = 1'b1;
    repeat (3) @(negedge clk1m);
    check("reset_frame_active", int'(frame_active), 0);
    check("reset_sym_data", int'(sym_data), 0);
    reset_n = 1'b1;

    // Short run is rejected; a MinPulse run fires once after its 4th edge and syncs.
    a = edge_cnt + 3;
    pin(a + 2, 0, 0, "short_run_pulse");
    pin(a + 3, 0, 0, "short_run_pulse");
    pin(a + 4, 0, 0, "short_run_pulse");
    drive_high(a, 1);
    b = a + 6;
    pin(b + 2, 0, 0, "run2_pulse_early");
    pin(b + 3, 0, 1, "run2_pulse_4th_edge");
    pin(b + 4, 0, 0, "run2_pulse_once");
    pin(b + 3, 4, 0, "sync_fa_before");
    pin(b + 4, 4, 1, "sync_fa_after");
    e = b;
    pin(e + 128, 1, 0, "f0_valid_early");
    pin(e + 129, 1, 1, "f0_valid");
    pin(e + 129, 3, 2, "f0_data");
    pin(e + 129, 4, 1, "f0_fa");
    pin(e + 130, 1, 0, "f0_valid_once");
    pin(e + 254, 1, 1, "f1_valid_cyc124");
    pin(e + 254, 3, 4, "f1_data");
    pin(e + 379, 3, 1, "f2_data");
    pin(e + 504, 1, 1, "f3_valid_cyc0");
    pin(e + 504, 3, 0, "f3_data");
    pin(e + 629, 3, 4, "f4_data");
    pin(e + 754, 2, 1, "f5_err_empty");
    pin(e + 754, 4, 1, "f5_fa_kept");
    pin(e + 879, 2, 1, "f6_err_double");
    pin(e + 879, 4, 0, "f6_fa_idle");
    pin(e + 879, 3, 4, "f6_data_held");
    pin(e + 880, 2, 0, "f6_err_once");
    drive_high(b, 2);
    drive_high(e + 1 + 60, 2);
    drive_high(e + 1 + 249, 2);
    drive_high(e + 1 + 280, 2);
    drive_high(e + 1 + 375, 2);
    drive_high(e + 1 + 600, 2);
    drive_high(e + 1 + 760, 2);
    drive_high(e + 1 + 800, 2);

    // Link-idle abort mid-frame, then a fresh sync.
    e2 = e + 900;
    pin(e2 + 74, 4, 1, "abort_fa_before");
    pin(e2 + 75, 4, 0, "abort_fa_after");
    pin(e2 + 129, 1, 0, "abort_no_valid");
    pin(e2 + 129, 2, 0, "abort_no_err");
    drive_high(e2, 2);
    drive_high(e2 + 1 + 40, 2);
    wait_neg(e2 + 74);
    auto_reset_n = 1'b0;
    @(negedge clk1m);
    auto_reset_n = 1'b1;
    e3 = e2 + 200;
    pin(e3 + 3, 4, 0, "resync_fa_before");
    pin(e3 + 4, 4, 1, "resync_fa_after");
    pin(e3 + 129, 1, 1, "resync_valid");
    pin(e3 + 129, 3, 3, "resync_data");
    drive_high(e3, 2);
    drive_high(e3 + 1 + 80, 2);

    // Pulses keep coming while the link is idle but must not start a frame.
    g = e3 + 140;
    pin(g - 1, 4, 1, "idle_fa_before");
    pin(g, 4, 0, "idle_fa_after");
    pin(g + 8, 0, 1, "idle_pulse_still");
    pin(g + 10, 4, 0, "idle_no_sync");
    wait_neg(g - 1);
    auto_reset_n = 1'b0;
    drive_high(g + 5, 2);
    wait_neg(g + 15);
    auto_reset_n = 1'b1;

    // Asynchronous reset in the middle of a frame.
    e4 = g + 30;
    pin(e4 + 34, 4, 1, "pre_rst_fa");
    pin(e4 + 34, 3, 3, "pre_rst_data");
    drive_high(e4, 2);
    drive_high(e4 + 11, 2);
    wait_neg(e4 + 34);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ppm_pulse", int'(ppm_pulse), 0);
    check("async_rst_sym_valid", int'(sym_valid), 0);
    check("async_rst_sym_err", int'(sym_err), 0);
    check("async_rst_sym_data", int'(sym_data), 0);
    check("async_rst_frame_active", int'(frame_active), 0);
    repeat (3) @(negedge clk1m);
    reset_n = 1'b1;
    e5 = edge_cnt + 10;
    pin(e5 - 1, 4, 0, "post_rst_idle");
    pin(e5 + 3, 4, 0, "post_rst_fa_before");
    pin(e5 + 4, 4, 1, "post_rst_fa_after");
    pin(e5 + 129, 1, 1, "post_rst_valid");
    pin(e5 + 129, 3, 2, "post_rst_data");
    drive_high(e5, 2);
    drive_high(e5 + 1 + 55, 2);
    wait_neg(e5 + 140);

    check("pins_visited", pins_hit, pins.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
